r5fp_int_sqrt: RTL and testbench

Dedicated iterative integer square-root responder for the `isqrt_*` handshake driven by `R5FP_sqrt`. It is a drop-in replacement for the combined divide/square-root engine when no divider is shared. It accepts a W-bit radicand operand, computes `Quo = floor(sqrt(D·2^W))` with a digit-recurrence restoring algorithm, and returns the root plus a remainder whose non-zero value signals an inexact result.

---
 rtl/r5fp_int_sqrt.sv | 167 ++++++++++++++++
 tb/tb_r5fp_int_sqrt.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r5fp_int_sqrt.sv
// ---------------------------------------------------------------------------
// r5fp_int_sqrt
//
// Iterative integer square-root responder for the isqrt_* handshake used by
// the floating-point square-root front end. It computes
//   Quo_o = floor(sqrt(D_i * 2^W))
// with a restoring digit recurrence, producing one root bit per cycle, or two
// when the radix-4 build is selected. Rem_o carries the remainder
// R - Quo^2, saturated to all ones when it does not fit in W bits. A non-zero
// remainder marks an inexact root.
//
// Build option:
//   R5FP_ISQRT_RADIX4_EN  defined   -> two root bits per cycle, W/2 iterations
//                         undefined -> one root bit per cycle, W iterations
//   Quo_o and Rem_o are identical in both builds; only the latency changes.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   D_i       in   W-bit radicand operand (effective radicand D_i * 2^W)
//   strobe_i  in   start request, honoured only while ready_o is high
//   Quo_o     out  W-bit root, held until the next accepted strobe
//   Rem_o     out  W-bit saturated remainder, held like Quo_o
//   done_o    out  one-cycle pulse, results valid
//   ready_o   out  idle, a strobe on the next edge is accepted
// ---------------------------------------------------------------------------
module r5fp_int_sqrt #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] D_i,
  input  logic         strobe_i,
  output logic [W-1:0] Quo_o,
  output logic [W-1:0] Rem_o,
  output logic         done_o,
  output logic         ready_o
);

  localparam int CW = $clog2(W + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

`ifdef R5FP_ISQRT_RADIX4_EN
  localparam logic [CW-1:0] ITERS = CW'(W / 2);
`else
  localparam logic [CW-1:0] ITERS = CW'(W);
`endif

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] rad_q, rad_d;
  logic [W-1:0]   root_q, root_d;
  logic [W+1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   remOut_q, remOut_d;
  logic           done_q, done_d;

  // Result of one radix-2 step, packed as {remainder, root}.
  logic [2*W+1:0] stepA;
`ifdef R5FP_ISQRT_RADIX4_EN
  logic [2*W+1:0] stepB;
`endif
  logic [W+1:0]   remNew;
  logic [W-1:0]   rootNew;

  // One restoring step: bring down two radicand bits, try subtracting
  // {root,01}, keep the difference and append a 1 if it did not go negative.
  // The full remainder takes part in the compare; its top bits are zero while
  // the recurrence invariant rem <= 2*root holds, so the shifted value is
  // exact in W+2 bits.
  function automatic logic [2*W+1:0] sqrtStep(input logic [W+1:0] rem,
                                              input logic [W-1:0] root,
                                              input logic [1:0]   bits);
    logic [W+1:0] remSh;
    logic [W+1:0] subtrahend;
    remSh      = {rem[W-1:0], bits};
    subtrahend = {root, 2'b01};
    if ({rem, bits} >= {2'b00, subtrahend}) begin
      sqrtStep = {remSh - subtrahend, root[W-2:0], 1'b1};
    end else begin
      sqrtStep = {remSh, root[W-2:0], 1'b0};
    end
  endfunction

  // Next-state logic: accept in IDLE, iterate in BUSY, and publish the
  // result registers only on the final iteration so they stay stable while
  // the working registers churn.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rad_d    = rad_q;
    root_d   = root_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    remOut_d = remOut_q;
    done_d   = 1'b0;

    stepA = sqrtStep(rem_q, root_q, rad_q[2*W-1:2*W-2]);
`ifdef R5FP_ISQRT_RADIX4_EN
    stepB   = sqrtStep(stepA[2*W+1:W], stepA[W-1:0], rad_q[2*W-3:2*W-4]);
    remNew  = stepB[2*W+1:W];
    rootNew = stepB[W-1:0];
`else
    remNew  = stepA[2*W+1:W];
    rootNew = stepA[W-1:0];
`endif

    case (state_q)
      ST_IDLE: begin
        if (strobe_i) begin
          state_d = ST_BUSY;
          rad_d   = {D_i, {W{1'b0}}};
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = ITERS;
        end
      end
      default: begin
`ifdef R5FP_ISQRT_RADIX4_EN
        rad_d = rad_q << 4;
`else
        rad_d = rad_q << 2;
`endif
        root_d = rootNew;
        rem_d  = remNew;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          quo_d    = rootNew;
          remOut_d = (remNew[W+1:W] != 2'b00) ? {W{1'b1}} : remNew[W-1:0];
        end
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rad_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      remOut_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rad_q    <= rad_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      remOut_q <= remOut_d;
      done_q   <= done_d;
    end
  end

  assign Quo_o   = quo_q;
  assign Rem_o   = remOut_q;
  assign done_o  = done_q;
  assign ready_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_r5fp_int_sqrt.sv
// ---------------------------------------------------------------------------
// tb_r5fp_int_sqrt
//
// Self-checking bench for r5fp_int_sqrt. A W=8 instance is driven from a
// table of hand-computed vectors plus hand-written sequences for
// back-to-back operation, a strobe while busy, and reset mid-iteration,
// then swept over all 256 operands. A W=26 instance gets directed and random
// operands. Expected roots come from a binary-search reference model.
// ---------------------------------------------------------------------------
module tb_r5fp_int_sqrt;

`ifdef R5FP_ISQRT_RADIX4_EN
  localparam int LAT8  = 4;
  localparam int LAT26 = 13;
`else
  localparam int LAT8  = 8;
  localparam int LAT26 = 26;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  D;
  logic        strobe;
  logic [7:0]  quo;
  logic [7:0]  rem;
  logic        done;
  logic        ready;

  logic [25:0] d26;
  logic        strobe26;
  logic [25:0] quo26;
  logic [25:0] rem26;
  logic        done26;
  logic        ready26;

  int nCompared = 0;
  int nMismatched = 0;

  r5fp_int_sqrt #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .D_i(D), .strobe_i(strobe),
    .Quo_o(quo), .Rem_o(rem), .done_o(done), .ready_o(ready)
  );

  r5fp_int_sqrt #(.W(26)) dut26 (
    .clk(clk), .reset(reset), .D_i(d26), .strobe_i(strobe26),
    .Quo_o(quo26), .Rem_o(rem26), .done_o(done26), .ready_o(ready26)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [7:0] quo;
    logic [7:0] rem;
  } vec_t;

  // Reference: largest x with x*x <= r, by binary search over [0, 2^27).
  function automatic longint unsigned refRoot(input longint unsigned r);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 27;
    while (hi - lo > 1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid <= r) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  function automatic longint unsigned refRem(input longint unsigned r, input int w);
    longint unsigned q, rm;
    q  = refRoot(r);
    rm = r - q * q;
    if (rm >= (64'd1 << w)) rm = (64'd1 << w) - 1;
    return rm;
  endfunction

  task automatic checkOutput(input string name, input longint unsigned act,
                             input longint unsigned exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one W=8 operation and return the number of edges after the
  // accepting edge until done is observed (bounded).
  task automatic applyStimulus(input logic [7:0] d, output int lat);
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    D = d;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    D = ~d;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic applyStimulus26(input logic [25:0] d, output int lat);
    int guard;
    guard = 0;
    while (!ready26 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    d26 = d;
    strobe26 = 1'b1;
    @(posedge clk);
    #1;
    strobe26 = 1'b0;
    d26 = ~d;
    lat = 0;
    while (!done26 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int lat;
    bit held;
    bit sawDone;
    longint unsigned r;
    logic [25:0] rnd;

    vecs[0] = '{d: 8'h40, quo: 8'h80, rem: 8'h00};
    vecs[1] = '{d: 8'h02, quo: 8'h16, rem: 8'h1C};
    vecs[2] = '{d: 8'hF6, quo: 8'hFA, rem: 8'hFF};
    vecs[3] = '{d: 8'h01, quo: 8'h10, rem: 8'h00};
    vecs[4] = '{d: 8'h03, quo: 8'h1B, rem: 8'h27};
    vecs[5] = '{d: 8'h80, quo: 8'hB5, rem: 8'h07};

    reset = 1'b1;
    D = '0;
    strobe = 1'b0;
    d26 = '0;
    strobe26 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_quo", quo, 0);
    checkOutput("reset_rem", rem, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ready", ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].d, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, LAT8);
      checkOutput($sformatf("vec%0d_quo", i), quo, vecs[i].quo);
      checkOutput($sformatf("vec%0d_rem", i), rem, vecs[i].rem);
      checkOutput($sformatf("vec%0d_ready", i), ready, 1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // Back-to-back: 0xFF, then 0x00 strobed in the done cycle of the first
    applyStimulus(8'hFF, lat);
    checkOutput("b2b_first_latency", lat, LAT8);
    checkOutput("b2b_first_quo", quo, 8'hFF);
    checkOutput("b2b_first_rem", rem, 8'hFF);
    @(negedge clk);
    D = 8'h00;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    D = 8'h5A;
    checkOutput("b2b_done_fell", done, 0);
    checkOutput("b2b_ready_fell", ready, 0);
    held = 1'b1;
    lat = 0;
    while (!done && lat < 100) begin
      if (quo !== 8'hFF || rem !== 8'hFF) held = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("b2b_results_held", held, 1);
    checkOutput("b2b_second_latency", lat, LAT8);
    checkOutput("b2b_second_quo", quo, 8'h00);
    checkOutput("b2b_second_rem", rem, 8'h00);

    // Strobe while busy is ignored
    @(negedge clk);
    D = 8'h02;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    D = 8'hF6;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    lat = 3;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("busy_strobe_latency", lat, LAT8);
    checkOutput("busy_strobe_quo", quo, 8'h16);
    checkOutput("busy_strobe_rem", rem, 8'h1C);
    @(posedge clk);
    #1;
    checkOutput("busy_strobe_no_restart", ready, 1);

    // Reset mid-iteration
    @(negedge clk);
    D = 8'h40;
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_quo", quo, 0);
    checkOutput("midreset_rem", rem, 0);
    checkOutput("midreset_ready", ready, 1);
    checkOutput("midreset_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("midreset_no_done", sawDone, 0);
    applyStimulus(8'h03, lat);
    checkOutput("postreset_latency", lat, LAT8);
    checkOutput("postreset_quo", quo, 8'h1B);
    checkOutput("postreset_rem", rem, 8'h27);

    // Full sweep at W=8
    for (int v = 0; v < 256; v++) begin
      applyStimulus(8'(v), lat);
      r = longint'(v) << 8;
      checkOutput($sformatf("sweep_quo_%0h", v), quo, refRoot(r));
      checkOutput($sformatf("sweep_rem_%0h", v), rem, refRem(r, 8));
    end

    // W=26: corners then random operands
    for (int k = 0; k < 300; k++) begin
      if (k == 0) rnd = '0;
      else if (k == 1) rnd = '1;
      else if (k == 2) rnd = 26'd1;
      else rnd = 26'($urandom);
      applyStimulus26(rnd, lat);
      r = longint'(rnd) << 26;
      if (k < 3) checkOutput($sformatf("w26_latency_%0d", k), lat, LAT26);
      checkOutput($sformatf("w26_quo_%0h", rnd), quo26, refRoot(r));
      checkOutput($sformatf("w26_rem_%0h", rnd), rem26, refRem(r, 26));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
